lcd_hex_formatter: RTL

- Upstream feeder for the LCD control stage: converts a binary word into a contiguous burst of ASCII hex characters.
- Drives that stage's `start_update`, `valid_i` and `char` inputs, and consumes its `update` pulse as burst acknowledge.
- Waits for the LCD to be idle (`lcd_busy` low) before starting a burst, then reports completion to the producer.

---
 rtl/lcd_hex_formatter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lcd_hex_formatter.sv
// Feeds the LCD control stage with a burst of ASCII hex characters for one binary word.
// Optional build macro LCD_ZERO_BLANK_EN: leading zero digits are sent as spaces.
module lcd_hex_formatter #(
    parameter int unsigned DIGITS = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   value_i,
    output logic                  ready_o,
    output logic                  start_update,
    output logic                  valid_o,
    output logic [7:0]            char_o,
    input  logic                  lcd_busy,
    input  logic                  update,
    output logic                  done_o
);

    generate
        if (DIGITS < 1 || DIGITS > 16) begin : g_bad_digits
            $error("lcd_hex_formatter: DIGITS must be in 1..16");
        end
    endgenerate

    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LastIdx = CW'(DIGITS - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StWaitLcd = 3'd1;
    localparam logic [2:0] StStart   = 3'd2;
    localparam logic [2:0] StSend    = 3'd3;
    localparam logic [2:0] StAck     = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic                done_q, done_d;
    logic [CW-1:0]       idx;
    logic [3:0]          nib;
    logic                blank;

`ifdef LCD_ZERO_BLANK_EN
    // Set once a nonzero digit has gone out in the current burst.
    logic seen_q, seen_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
`ifdef LCD_ZERO_BLANK_EN
        seen_d   = seen_q;
`endif
        case (state_q)
            StIdle: begin
                if (load_i) begin
                    shadow_d = value_i;
                    state_d  = StWaitLcd;
                end
            end
            StWaitLcd: begin
                if (!lcd_busy) state_d = StStart;
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StSend;
`ifdef LCD_ZERO_BLANK_EN
                seen_d  = 1'b0;
`endif
            end
            StSend: begin
`ifdef LCD_ZERO_BLANK_EN
                if (nib != 4'h0) seen_d = 1'b1;
`endif
                if (cnt_q == LastIdx) begin
                    cnt_d   = '0;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAck: begin
                if (update) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
`ifdef LCD_ZERO_BLANK_EN
            seen_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
`ifdef LCD_ZERO_BLANK_EN
            seen_q   <= seen_d;
`endif
        end
    end

    // Most-significant nibble goes out first.
    always_comb begin
        idx = LastIdx - cnt_q;
        nib = shadow_q[{idx, 2'b00} +: 4];
`ifdef LCD_ZERO_BLANK_EN
        blank = !seen_q && (nib == 4'h0) && (cnt_q != LastIdx);
`else
        blank = 1'b0;
`endif
    end

    always_comb begin
        ready_o      = (state_q == StIdle);
        start_update = (state_q == StStart);
        valid_o      = (state_q == StSend);
        done_o       = done_q;
        char_o       = 8'h00;
        if (valid_o) begin
            if (blank)            char_o = 8'h20;
            else if (nib < 4'd10) char_o = 8'h30 + {4'h0, nib};
            else                  char_o = 8'h37 + {4'h0, nib};
        end
    end

endmodule
